// File: rtl/spi_master_shifter_pkg.sv
// Shared SPI master definitions: FSM state encodings, pad idle levels and a
// helper that picks the wire-order head bit of a parallel word.
package spi_master_shifter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4
    } spi_state_e;

    localparam logic SPI_IDLE_CS_N = 1'b1;
    localparam logic SPI_IDLE_SCLK = 1'b0;

    function automatic logic head_bit(input logic [31:0] word,
                                      input int unsigned width,
                                      input logic        msb_first);
        logic [4:0] idx;
        idx = 5'(width - 32'd1);
        return msb_first ? word[idx] : word[0];
    endfunction

endpackage

// File: rtl/spi_master_shifter_shift_reg.sv
// Parallel-load shift register for one SPI direction; the head bit (the one on
// the wire) is bit WIDTH-1 when MSB_FIRST, otherwise bit 0.
module spi_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] par_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            if (MSB_FIRST != 0) begin
                sr_d = {sr_q[WIDTH-2:0], ser_i};
            end else begin
                sr_d = {ser_i, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_o = sr_q;

endmodule

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master: one full-duplex transaction per accepted start, with all
// pad outputs and status driven from registers.
module spi_master_shifter
    import spi_master_shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
    output logic             CS_N
);

    localparam int unsigned   CW        = $clog2(CLK_DIV);
    localparam int unsigned   BW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(WIDTH);

    spi_state_e       state_q;
    logic [CW-1:0]    half_q;
    logic [BW-1:0]    bits_q;
    logic             tail_q;
    logic             sclk_q;
    logic             cs_n_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] rx_data_q;

    logic             half_end;
    logic             tx_load;
    logic [WIDTH-1:0] tx_word;
    logic             tx_shift;
    logic             rx_shift;
    logic [WIDTH-1:0] tx_par;
    logic [WIDTH-1:0] rx_par;

    assign half_end = (half_q == HALF_LAST);

    // Shift strobes fire on the same edge as the matching SCLK transition.
    always_comb begin
        tx_load  = 1'b0;
        tx_word  = '0;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_load = start;
                tx_word = tx_data;
            end
            ST_SETUP, ST_LOW: rx_shift = half_end;
            ST_HIGH:          tx_shift = half_end && (bits_q != BITS_ALL);
            ST_HOLD:          tx_load  = half_end && tail_q;
            default: ;
        endcase
    end

    spi_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
        .CLK         (CLK),
        .CLR         (CLR),
        .load_i      (tx_load),
        .load_data_i (tx_word),
        .shift_i     (tx_shift),
        .ser_i       (1'b0),
        .par_o       (tx_par)
    );

    spi_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
        .CLK         (CLK),
        .CLR         (CLR),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .ser_i       (MISO),
        .par_o       (rx_par)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            half_q    <= '0;
            bits_q    <= '0;
            tail_q    <= 1'b0;
            sclk_q    <= SPI_IDLE_SCLK;
            cs_n_q    <= SPI_IDLE_CS_N;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                half_q <= half_end ? '0 : half_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_SETUP;
                    cs_n_q  <= ~SPI_IDLE_CS_N;
                    busy_q  <= 1'b1;
                    bits_q  <= '0;
                    tail_q  <= 1'b0;
                    half_q  <= '0;
                end
                ST_SETUP, ST_LOW: if (half_end) begin
                    sclk_q  <= ~SPI_IDLE_SCLK;
                    bits_q  <= bits_q + 1'b1;
                    state_q <= ST_HIGH;
                end
                ST_HIGH: if (half_end) begin
                    sclk_q  <= SPI_IDLE_SCLK;
                    state_q <= (bits_q == BITS_ALL) ? ST_HOLD : ST_LOW;
                end
                // HOLD spans two half-periods so CS_N rises a full SCLK period after the last fall.
                ST_HOLD: if (half_end) begin
                    if (!tail_q) begin
                        tail_q <= 1'b1;
                    end else begin
                        cs_n_q    <= SPI_IDLE_CS_N;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_par;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign SCLK    = sclk_q;
    assign CS_N    = cs_n_q;
    assign MOSI    = head_bit(32'(tx_par), WIDTH, MSB_FIRST != 0);

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: an MSB-first and an LSB-first instance checked
// cycle by cycle against a frame-timing reference model.
module tb_spi_master_shifter;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int FR   = (2 * W + 2) * D;
    localparam int NMAX = 2 * FR + 8;

    logic CLK = 1'b0;
    logic CLR = 1'b0;

    logic         st   [2];
    logic [W-1:0] txd  [2];
    logic         mi   [2];
    logic         bsy  [2];
    logic         dn   [2];
    logic [W-1:0] rx   [2];
    logic         sck  [2];
    logic         mo   [2];
    logic         csn  [2];

    logic [4:0]   obs_pins [NMAX];
    logic [W-1:0] obs_rx   [NMAX];
    logic [W-1:0] last_rx  [2];

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    spi_master_shifter #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(1)) dut_msb (
        .CLK(CLK), .CLR(CLR), .start(st[0]), .tx_data(txd[0]), .busy(bsy[0]), .done(dn[0]),
        .rx_data(rx[0]), .SCLK(sck[0]), .MOSI(mo[0]), .MISO(mi[0]), .CS_N(csn[0])
    );

    spi_master_shifter #(.WIDTH(W), .CLK_DIV(D), .MSB_FIRST(0)) dut_lsb (
        .CLK(CLK), .CLR(CLR), .start(st[1]), .tx_data(txd[1]), .busy(bsy[1]), .done(dn[1]),
        .rx_data(rx[1]), .SCLK(sck[1]), .MOSI(mo[1]), .MISO(mi[1]), .CS_N(csn[1])
    );

    // Bit of a word that is on the wire during data slot j.
    function automatic logic wire_bit(input logic [W-1:0] word, input int j, input bit lsb);
        int k;
        k = (j > W - 1) ? W - 1 : j;
        return lsb ? word[k] : word[W-1-k];
    endfunction

    // Expected {cs_n, busy, sclk, mosi, done} n cycles after the accepted-start edge.
    function automatic logic [4:0] model_pins(input int n, input logic [W-1:0] tx, input bit lsb);
        int  m;
        logic s;
        if (n < 0 || n > FR) return 5'b10000;
        if (n == FR) return 5'b10001;
        m = n / D;
        s = (m % 2 == 1) && (m < 2 * W);
        return {1'b0, 1'b1, s, wire_bit(tx, n / (2 * D), lsb), 1'b0};
    endfunction

    // Starts a frame on instance s and records outputs after each edge t0+n.
    task automatic drive_frame(input int s, input logic [W-1:0] txa, input logic [W-1:0] txb,
                               input logic [W-1:0] pat, input bit loopback, input bit hold,
                               input int pa, input int pb, input int nobs);
        @(negedge CLK);
        st[s]  = 1'b1;
        txd[s] = txa;
        mi[s]  = loopback ? 1'b0 : wire_bit(pat, 0, s == 1);
        for (int n = 0; n < nobs; n++) begin
            @(posedge CLK);
            #1;
            obs_pins[n] = {csn[s], bsy[s], sck[s], mo[s], dn[s]};
            obs_rx[n]   = rx[s];
            if (hold) begin
                st[s]  = (n <= FR);
                txd[s] = (n <= FR) ? txb : W'($urandom);
            end else begin
                st[s]  = (n + 1 == pa) || (n + 1 == pb);
                txd[s] = W'($urandom);
            end
            mi[s] = loopback ? mo[s] : wire_bit(pat, n / (2 * D), s == 1);
        end
        st[s] = 1'b0;
    endtask

    task automatic test_reset;
        #1 CLR = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({csn[s], bsy[s], sck[s], mo[s], dn[s]} !== 5'b10000 || rx[s] !== '0) begin
                failures++;
                $display("FAIL reset_state dut=%0d got pins=%b rx=%h exp pins=10000 rx=00",
                         s, {csn[s], bsy[s], sck[s], mo[s], dn[s]}, rx[s]);
            end
            last_rx[s] = '0;
        end
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic test_loopback;
        logic [W-1:0] tx;
        logic [4:0]   e;
        logic [W-1:0] er;
        for (int f = 0; f < 4; f++) begin
            tx = (f == 0) ? 8'hA5 : W'($urandom);
            drive_frame(0, tx, '0, '0, 1'b1, 1'b0, -1, -1, FR + 2);
            for (int n = 0; n < FR + 2; n++) begin
                e  = model_pins(n, tx, 1'b0);
                er = (n < FR) ? last_rx[0] : tx;
                checks++;
                if (obs_pins[n] !== e || obs_rx[n] !== er) begin
                    failures++;
                    $display("FAIL loopback tx=%h n=%0d got pins=%b rx=%h exp pins=%b rx=%h",
                             tx, n, obs_pins[n], obs_rx[n], e, er);
                end
            end
            last_rx[0] = tx;
        end
    endtask

    task automatic test_miso_pattern;
        logic [W-1:0] tx;
        logic [W-1:0] pat;
        logic [4:0]   e;
        logic [W-1:0] er;
        for (int f = 0; f < 3; f++) begin
            tx  = W'($urandom);
            pat = (f == 0) ? 8'h3C : W'($urandom);
            drive_frame(0, tx, '0, pat, 1'b0, 1'b0, -1, -1, FR + 2);
            for (int n = 0; n < FR + 2; n++) begin
                e  = model_pins(n, tx, 1'b0);
                er = (n < FR) ? last_rx[0] : pat;
                checks++;
                if (obs_pins[n] !== e || obs_rx[n] !== er) begin
                    failures++;
                    $display("FAIL miso_msb pat=%h n=%0d got pins=%b rx=%h exp pins=%b rx=%h",
                             pat, n, obs_pins[n], obs_rx[n], e, er);
                end
            end
            last_rx[0] = pat;
        end
    endtask

    task automatic test_lsb_first;
        logic [W-1:0] tx;
        logic [W-1:0] pat;
        logic [4:0]   e;
        logic [W-1:0] er;
        for (int f = 0; f < 3; f++) begin
            tx  = (f == 1) ? 8'h01 : W'($urandom);
            pat = (f == 0) ? 8'h3C : W'($urandom);
            drive_frame(1, tx, '0, pat, f == 2, 1'b0, -1, -1, FR + 2);
            if (f == 2) pat = tx;
            for (int n = 0; n < FR + 2; n++) begin
                e  = model_pins(n, tx, 1'b1);
                er = (n < FR) ? last_rx[1] : pat;
                checks++;
                if (obs_pins[n] !== e || obs_rx[n] !== er) begin
                    failures++;
                    $display("FAIL lsb_first pat=%h n=%0d got pins=%b rx=%h exp pins=%b rx=%h",
                             pat, n, obs_pins[n], obs_rx[n], e, er);
                end
            end
            last_rx[1] = pat;
        end
    endtask

    task automatic test_start_while_busy;
        logic [4:0]   e;
        logic [W-1:0] er;
        drive_frame(0, 8'h81, '0, '0, 1'b1, 1'b0, 10, 40, FR + 6);
        for (int n = 0; n < FR + 6; n++) begin
            e  = model_pins(n, 8'h81, 1'b0);
            er = (n < FR) ? last_rx[0] : 8'h81;
            checks++;
            if (obs_pins[n] !== e || obs_rx[n] !== er) begin
                failures++;
                $display("FAIL start_while_busy n=%0d got pins=%b rx=%h exp pins=%b rx=%h",
                         n, obs_pins[n], obs_rx[n], e, er);
            end
        end
        last_rx[0] = 8'h81;
    endtask

    task automatic test_back_to_back;
        logic [4:0]   e;
        logic [W-1:0] er;
        int           dones;
        dones = 0;
        drive_frame(0, 8'h12, 8'h34, '0, 1'b1, 1'b1, -1, -1, 2 * FR + 4);
        for (int n = 0; n < 2 * FR + 4; n++) begin
            e  = (n <= FR) ? model_pins(n, 8'h12, 1'b0) : model_pins(n - FR - 1, 8'h34, 1'b0);
            er = (n < FR) ? last_rx[0] : ((n < 2 * FR + 1) ? 8'h12 : 8'h34);
            if (obs_pins[n][0] === 1'b1) dones++;
            checks++;
            if (obs_pins[n] !== e || obs_rx[n] !== er) begin
                failures++;
                $display("FAIL back_to_back n=%0d got pins=%b rx=%h exp pins=%b rx=%h",
                         n, obs_pins[n], obs_rx[n], e, er);
            end
        end
        checks++;
        if (dones != 2 || obs_pins[FR][0] !== 1'b1 || obs_pins[2 * FR + 1][0] !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back_done_spacing got dones=%0d exp 2 pulses at n=%0d and n=%0d",
                     dones, FR, 2 * FR + 1);
        end
        last_rx[0] = 8'h34;
    endtask

    task automatic test_clr_abort;
        logic [W-1:0] tx;
        logic [4:0]   e;
        logic [W-1:0] er;
        tx = W'($urandom) | 8'h01;
        @(negedge CLK);
        st[0]  = 1'b1;
        txd[0] = tx;
        for (int n = 0; n <= 30; n++) begin
            @(posedge CLK);
            #1;
            st[0] = 1'b0;
        end
        checks++;
        if (bsy[0] !== 1'b1 || csn[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_pre_clr got busy=%b cs_n=%b exp busy=1 cs_n=0", bsy[0], csn[0]);
        end
        #1 CLR = 1'b1;
        #1;
        checks++;
        if ({csn[0], bsy[0], sck[0], mo[0], dn[0]} !== 5'b10000 || rx[0] !== '0) begin
            failures++;
            $display("FAIL abort_immediate got pins=%b rx=%h exp pins=10000 rx=00",
                     {csn[0], bsy[0], sck[0], mo[0], dn[0]}, rx[0]);
        end
        @(negedge CLK);
        CLR = 1'b0;
        last_rx[0] = '0;
        last_rx[1] = '0;
        for (int n = 0; n < FR + 8; n++) begin
            @(posedge CLK);
            #1;
            checks++;
            if ({csn[0], bsy[0], sck[0], mo[0], dn[0]} !== 5'b10000) begin
                failures++;
                $display("FAIL abort_no_done n=%0d got pins=%b exp pins=10000",
                         n, {csn[0], bsy[0], sck[0], mo[0], dn[0]});
            end
        end
        drive_frame(0, tx, '0, '0, 1'b1, 1'b0, -1, -1, FR + 2);
        for (int n = 0; n < FR + 2; n++) begin
            e  = model_pins(n, tx, 1'b0);
            er = (n < FR) ? 8'h00 : tx;
            checks++;
            if (obs_pins[n] !== e || obs_rx[n] !== er) begin
                failures++;
                $display("FAIL abort_recovery n=%0d got pins=%b rx=%h exp pins=%b rx=%h",
                         n, obs_pins[n], obs_rx[n], e, er);
            end
        end
        last_rx[0] = tx;
    endtask

    task automatic test_reset_idle;
        @(negedge CLK);
        #2 CLR = 1'b1;
        #1;
        checks++;
        if ({csn[0], bsy[0], sck[0], mo[0], dn[0]} !== 5'b10000 || rx[0] !== '0) begin
            failures++;
            $display("FAIL reset_idle got pins=%b rx=%h exp pins=10000 rx=00 (prev rx=%h)",
                     {csn[0], bsy[0], sck[0], mo[0], dn[0]}, rx[0], last_rx[0]);
        end
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            st[s]  = 1'b0;
            txd[s] = '0;
            mi[s]  = 1'b0;
        end
        test_reset();
        test_loopback();
        test_miso_pattern();
        test_lsb_first();
        test_start_while_busy();
        test_back_to_back();
        test_clr_abort();
        test_reset_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
